div_16x8_seq: RTL and testbench

DIV_16X8_SEQ -- requirements
Module: div_16x8_seq

---
 rtl/div_16x8_seq_if.sv | 37 +++
 rtl/div_16x8_seq.sv | 147 ++++++++++++++
 tb/tb_div_16x8_seq.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/div_16x8_seq_if.sv
// Operand/result handshake bundle for the sequential divider.
// The dbz flag exists only when DIV_DBZ_FLAG_EN is defined.
`timescale 1ns/1ps
interface div_16x8_seq_if #(
  parameter int DVD_W = 16,
  parameter int DVS_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [DVD_W-1:0] dividend;
  logic [DVS_W-1:0] divisor;
  logic             out_valid;
  logic             out_ready;
  logic [DVD_W-1:0] quotient;
  logic [DVS_W-1:0] remainder;
`ifdef DIV_DBZ_FLAG_EN
  logic             dbz;
`endif

  // Producer of operands and consumer of results.
  modport master (
    output in_valid, dividend, divisor, out_ready,
`ifdef DIV_DBZ_FLAG_EN
    input  dbz,
`endif
    input  in_ready, out_valid, quotient, remainder
  );

  // The divider itself.
  modport slave (
    input  in_valid, dividend, divisor, out_ready,
`ifdef DIV_DBZ_FLAG_EN
    output dbz,
`endif
    output in_ready, out_valid, quotient, remainder
  );
endinterface

// File: rtl/div_16x8_seq.sv
// Sequential restoring divider: DVD_W-bit unsigned dividend by DVS_W-bit
// unsigned divisor, one quotient bit per clock, MSB first.
// Three-state FSM IDLE -> CALC -> DONE with valid/ready on both sides.
// Divide by zero returns quotient all ones and remainder = low dividend bits.
// Optional macro DIV_DBZ_FLAG_EN adds a registered divide-by-zero flag (dbz).
// DVS_W must not exceed DVD_W, and DVD_W must be at least 2.
`timescale 1ns/1ps
module div_16x8_seq #(
  parameter int DVD_W = 16,
  parameter int DVS_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  div_16x8_seq_if.slave     bus
);

  localparam int CNT_W = (DVD_W > 1) ? $clog2(DVD_W) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  // r_work starts as the dividend; each step shifts one dividend bit out of
  // the top and one quotient bit into the bottom, so it ends as the quotient.
  logic [DVD_W-1:0]   r_work;
  logic [DVS_W-1:0]   r_part;
  logic [DVS_W-1:0]   r_dvs;
  logic [DVD_W-1:0]   r_quotient;
  logic [DVS_W-1:0]   r_remainder;
  logic               r_in_ready;
  logic               r_out_valid;
`ifdef DIV_DBZ_FLAG_EN
  logic               r_dbz;
`endif

  logic [DVS_W:0]     w_shift;
  logic [DVS_W+1:0]   w_diff;
  logic               w_ge;
  logic [DVS_W:0]     w_rem_full;
  logic [DVS_W-1:0]   w_part_nxt;
  logic [DVD_W-1:0]   w_work_nxt;
  logic               w_unused_msb;

  // One restoring step: shift in the next dividend bit, trial-subtract the
  // divisor with an extra sign bit, keep the difference when non-negative.
  always_comb begin
    w_shift    = {r_part, r_work[DVD_W-1]};
    w_diff     = {1'b0, w_shift} - {2'b00, r_dvs};
    w_ge       = ~w_diff[DVS_W+1];
    w_rem_full = w_ge ? w_diff[DVS_W:0] : w_shift;
    // The partial remainder is always below the divisor, so the top bit of
    // the selected value is zero and only the low DVS_W bits are kept.
    w_part_nxt = w_rem_full[DVS_W-1:0];
    w_work_nxt = {r_work[DVD_W-2:0], w_ge};
  end

  assign w_unused_msb = w_rem_full[DVS_W];

  // Control FSM plus datapath registers; all outputs are registered here.
  // NOTE: sequential state uses non-blocking assignments and the reset is in
  // the sensitivity list so it takes effect without waiting for a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_work      <= '0;
      r_part      <= '0;
      r_dvs       <= '0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
`ifdef DIV_DBZ_FLAG_EN
      r_dbz       <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          // in_ready is high throughout IDLE, so in_valid alone is the handshake.
          if (bus.in_valid) begin
            r_work     <= bus.dividend;
            r_dvs      <= bus.divisor;
            r_part     <= '0;
            r_cnt      <= CNT_W'(DVD_W - 1);
            r_in_ready <= 1'b0;
            r_state    <= CALC;
          end
        end

        CALC: begin
          if (r_dvs == '0) begin
            // Zero divisor skips iteration; result ready one cycle after capture.
            r_quotient  <= '1;
            r_remainder <= r_work[DVS_W-1:0];
            r_out_valid <= 1'b1;
`ifdef DIV_DBZ_FLAG_EN
            r_dbz       <= 1'b1;
`endif
            r_state     <= DONE;
          end else begin
            r_work <= w_work_nxt;
            r_part <= w_part_nxt;
            if (r_cnt == '0) begin
              r_quotient  <= w_work_nxt;
              r_remainder <= w_part_nxt;
              r_out_valid <= 1'b1;
`ifdef DIV_DBZ_FLAG_EN
              r_dbz       <= 1'b0;
`endif
              r_state     <= DONE;
            end else begin
              r_cnt <= r_cnt - 1'b1;
            end
          end
        end

        DONE: begin
          // Results hold until the consumer takes them.
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end

        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.quotient  = r_quotient;
  assign bus.remainder = r_remainder;
`ifdef DIV_DBZ_FLAG_EN
  assign bus.dbz       = r_dbz;
`endif

endmodule

// File: tb/tb_div_16x8_seq.sv
// Self-checking bench for div_16x8_seq: directed vectors, backpressure,
// reset abort and a randomized sweep against an arithmetic reference model.
`timescale 1ns/1ps
module tb_div_16x8_seq;

  localparam int DVD_W = 16;
  localparam int DVS_W = 8;
  // Edges from the input handshake edge to the edge after which out_valid is high.
  localparam int LAT_NORM = DVD_W;
  localparam int LAT_DBZ  = 1;
  localparam int WAIT_MAX = 40;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  div_16x8_seq_if #(.DVD_W(DVD_W), .DVS_W(DVS_W)) bus ();

  div_16x8_seq #(.DVD_W(DVD_W), .DVS_W(DVS_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference: plain integer division with the zero-divisor convention.
  function automatic void model(input logic [DVD_W-1:0] a, input logic [DVS_W-1:0] b,
                                output logic [DVD_W-1:0] q, output logic [DVS_W-1:0] r,
                                output logic z);
    int ia;
    int ib;
    ia = int'(a);
    ib = int'(b);
    if (ib == 0) begin
      q = '1;
      r = a[DVS_W-1:0];
      z = 1'b1;
    end else begin
      q = DVD_W'(ia / ib);
      r = DVS_W'(ia % ib);
      z = 1'b0;
    end
  endfunction

  // NOTE: outputs are sampled and inputs driven 1 ns after the rising edge,
  // well away from the edge the DUT samples on.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for in_ready, then hand over one operand pair and scramble
  // the operand inputs right after the capture edge.
  task automatic start_op(input logic [DVD_W-1:0] a, input logic [DVS_W-1:0] b);
    int t;
    t = 0;
    while (!bus.in_ready && t < WAIT_MAX) begin
      tick();
      t++;
    end
    if (!bus.in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL start_in_ready: in_ready=%0b required 1", bus.in_ready);
    end
    bus.in_valid = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    tick();
    bus.in_valid = 1'b0;
    bus.dividend = DVD_W'($urandom);
    bus.divisor  = DVS_W'($urandom);
  endtask

  // Count edges until out_valid, toggling ignored inputs meanwhile.
  task automatic wait_result(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < WAIT_MAX) begin
      bus.in_valid = 1'($urandom);
      bus.dividend = DVD_W'($urandom);
      bus.divisor  = DVS_W'($urandom);
      tick();
      lat++;
    end
  endtask

  // Take the result with an output handshake.
  task automatic pop_result(output logic [DVD_W-1:0] q, output logic [DVS_W-1:0] r,
                            output logic z);
    q = bus.quotient;
    r = bus.remainder;
`ifdef DIV_DBZ_FLAG_EN
    z = bus.dbz;
`else
    z = 1'b0;
`endif
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready: got %0b required 1", bus.in_ready);
    end
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_out_valid: got %0b required 0", bus.out_valid);
    end
    n_checks++;
    if (bus.quotient !== '0) begin
      n_fail++; $display("FAIL reset_quotient: got %h required 0", bus.quotient);
    end
    n_checks++;
    if (bus.remainder !== '0) begin
      n_fail++; $display("FAIL reset_remainder: got %h required 0", bus.remainder);
    end
`ifdef DIV_DBZ_FLAG_EN
    n_checks++;
    if (bus.dbz !== 1'b0) begin
      n_fail++; $display("FAIL reset_dbz: got %0b required 0", bus.dbz);
    end
`endif
  endtask

  typedef struct {
    logic [DVD_W-1:0] a;
    logic [DVS_W-1:0] b;
    logic [DVD_W-1:0] q;
    logic [DVS_W-1:0] r;
    int               lat;
  } vec_t;

  task automatic test_directed();
    vec_t vecs [4];
    logic [DVD_W-1:0] q;
    logic [DVS_W-1:0] r;
    logic z;
    int lat;
    vecs[0] = '{16'hFFFF, 8'hFF, 16'h0101, 8'h00, LAT_NORM};
    vecs[1] = '{16'd1000, 8'd7,  16'd142,  8'd6,  LAT_NORM};
    vecs[2] = '{16'h0005, 8'h09, 16'h0000, 8'h05, LAT_NORM};
    vecs[3] = '{16'h1234, 8'h00, 16'hFFFF, 8'h34, LAT_DBZ};
    for (int i = 0; i < 4; i++) begin
      start_op(vecs[i].a, vecs[i].b);
      wait_result(lat);
      pop_result(q, r, z);
      n_checks++;
      if (lat !== vecs[i].lat) begin
        n_fail++; $display("FAIL dir%0d_latency: got %0d required %0d", i, lat, vecs[i].lat);
      end
      n_checks++;
      if (q !== vecs[i].q) begin
        n_fail++; $display("FAIL dir%0d_quotient: got %h required %h", i, q, vecs[i].q);
      end
      n_checks++;
      if (r !== vecs[i].r) begin
        n_fail++; $display("FAIL dir%0d_remainder: got %h required %h", i, r, vecs[i].r);
      end
`ifdef DIV_DBZ_FLAG_EN
      n_checks++;
      if (z !== (vecs[i].b == '0)) begin
        n_fail++; $display("FAIL dir%0d_dbz: got %0b required %0b", i, z, (vecs[i].b == '0));
      end
`endif
      n_checks++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
        n_fail++; $display("FAIL dir%0d_return_idle: in_ready=%0b out_valid=%0b required 1/0",
                           i, bus.in_ready, bus.out_valid);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [DVD_W-1:0] eq;
    logic [DVS_W-1:0] er;
    logic ez;
    int lat;
    model(16'hABCD, 8'h3C, eq, er, ez);
    start_op(16'hABCD, 8'h3C);
    wait_result(lat);
    for (int c = 0; c < 5; c++) begin
      bus.in_valid = ~bus.in_valid;
      bus.dividend = DVD_W'($urandom);
      bus.divisor  = DVS_W'($urandom);
      tick();
      n_checks++;
      if (bus.quotient !== eq || bus.remainder !== er) begin
        n_fail++; $display("FAIL bp%0d_hold: got q=%h r=%h required q=%h r=%h",
                           c, bus.quotient, bus.remainder, eq, er);
      end
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
        n_fail++; $display("FAIL bp%0d_flags: out_valid=%0b in_ready=%0b required 1/0",
                           c, bus.out_valid, bus.in_ready);
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    n_checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL bp_release: in_ready=%0b out_valid=%0b required 1/0",
                         bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_reset_abort();
    logic [DVD_W-1:0] q;
    logic [DVS_W-1:0] r;
    logic z;
    int lat;
    int seen;
    start_op(16'h9999, 8'h07);
    for (int c = 0; c < 8; c++) tick();
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL abort_async: in_ready=%0b out_valid=%0b required 1/0",
                         bus.in_ready, bus.out_valid);
    end
    tick();
    tick();
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (bus.out_valid) seen++;
    end
    n_checks++;
    if (seen !== 0) begin
      n_fail++; $display("FAIL abort_no_result: out_valid cycles=%0d required 0", seen);
    end
    start_op(16'h00FF, 8'h10);
    wait_result(lat);
    pop_result(q, r, z);
    n_checks++;
    if (lat !== LAT_NORM) begin
      n_fail++; $display("FAIL abort_latency: got %0d required %0d", lat, LAT_NORM);
    end
    n_checks++;
    if (q !== 16'h000F || r !== 8'h0F) begin
      n_fail++; $display("FAIL abort_first_result: got q=%h r=%h required q=000f r=0f", q, r);
    end
  endtask

  task automatic test_random();
    logic [DVD_W-1:0] a;
    logic [DVS_W-1:0] b;
    logic [DVD_W-1:0] q;
    logic [DVS_W-1:0] r;
    logic z;
    logic [DVD_W-1:0] eq;
    logic [DVS_W-1:0] er;
    logic ez;
    int lat;
    int elat;
    for (int i = 0; i < 2000; i++) begin
      a = DVD_W'($urandom);
      b = DVS_W'($urandom);
      case (i % 8)
        0: b = 8'd1;
        1: a = '0;
        2: b = '0;
        3: a = '1;
        default: ;
      endcase
      model(a, b, eq, er, ez);
      elat = (b == '0) ? LAT_DBZ : LAT_NORM;
      start_op(a, b);
      wait_result(lat);
      pop_result(q, r, z);
      n_checks++;
      if (q !== eq || r !== er || lat !== elat) begin
        n_fail++; $display("FAIL rnd%0d %h/%h: got q=%h r=%h lat=%0d required q=%h r=%h lat=%0d",
                           i, a, b, q, r, lat, eq, er, elat);
      end
`ifdef DIV_DBZ_FLAG_EN
      n_checks++;
      if (z !== ez) begin
        n_fail++; $display("FAIL rnd%0d_dbz: got %0b required %0b", i, z, ez);
      end
`endif
      n_checks++;
      if (bus.in_ready !== 1'b1) begin
        n_fail++; $display("FAIL rnd%0d_in_ready_after_pop: got %0b required 1", i, bus.in_ready);
      end
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    tick();
    test_directed();
    test_backpressure();
    test_reset_abort();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
